hazard_ctrl: RTL

- Parametrised successor to the 5-stage MIPS pipeline hazard unit.
- Keeps EX-stage forwarding and load-use stalling, and adds a selectable branch-resolution stage (D or E) with forwarding into the D-stage branch comparator.
- Adds a multi-cycle mul/div occupancy FSM that holds the E stage, and a saturating stall-cycle performance counter.
- Sits beside the datapath and drives stage enables/clears for the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/muldiv_tracker.sv | 60 ++++++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// mul/div occupancy states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks a multi-cycle mul/div instruction in E and requests an E-stage hold
// until its MD_LAT-cycle occupancy has elapsed.
module muldiv_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic muldiv_e,
    output logic md_stall,
    output logic md_busy
);

    localparam int unsigned CW       = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam bit          MD_EN    = (MD_LAT > 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((MD_LAT > 1) ? (MD_LAT - 2) : 0);

    md_state_t     state_q;
    logic [CW-1:0] cnt_q;

    // Entry cycle counts as the first of MD_LAT; cnt reaching zero is the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (muldiv_e && MD_EN) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    always_comb begin
        md_stall = 1'b0;
        md_busy  = 1'b0;
        if (!reset) begin
            md_busy = (state_q == MD_BUSY);
            if (state_q == MD_IDLE) begin
                md_stall = muldiv_e && MD_EN;
            end else begin
                md_stall = (cnt_q != '0);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard unit: EX/D forwarding, load-use and branch stalls,
// mul/div E-stage hold, stage flushes and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned BRANCH_IN_D = 0,
    parameter int unsigned MD_LAT      = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic [REG_W-1:0] writereg_m,
    input  logic [REG_W-1:0] writereg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             branch_d,
    input  logic             muldiv_e,
    input  logic             pcsrc,
    input  logic             clr_count,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam bit BR_IN_D = (BRANCH_IN_D != 0);

    logic             md_stall;
    logic             lw_stall;
    logic             br_stall;
    logic             any_stall;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    muldiv_tracker #(
        .MD_LAT(MD_LAT)
    ) u_md (
        .clk     (clk),
        .reset   (reset),
        .muldiv_e(muldiv_e),
        .md_stall(md_stall),
        .md_busy (md_busy)
    );

    function automatic fwd_sel_t ex_fwd(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] wr_m,
        input logic             rw_m,
        input logic [REG_W-1:0] wr_w,
        input logic             rw_w
    );
        if (src != '0 && src == wr_m && rw_m) begin
            return FWD_MEM;
        end else if (src != '0 && src == wr_w && rw_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        lw_stall = memtoreg_e && regwrite_e && (writereg_e != '0)
                   && (writereg_e == rs_d || writereg_e == rt_d);
        br_stall = BR_IN_D && branch_d
                   && ((regwrite_e && (writereg_e != '0)
                        && (writereg_e == rs_d || writereg_e == rt_d))
                    || (memtoreg_m && (writereg_m != '0)
                        && (writereg_m == rs_d || writereg_m == rt_d)));
        any_stall = md_stall | lw_stall | br_stall;
    end

    // All stage controls are forced low while reset is asserted.
    always_comb begin
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        forward_a_d = 1'b0;
        forward_b_d = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        if (!reset) begin
            forward_a_e = ex_fwd(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
            forward_b_e = ex_fwd(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
            forward_a_d = BR_IN_D && (rs_d != '0) && (rs_d == writereg_m) && regwrite_m;
            forward_b_d = BR_IN_D && (rt_d != '0) && (rt_d == writereg_m) && regwrite_m;
            stall_f     = any_stall;
            stall_d     = any_stall;
            stall_e     = md_stall;
            flush_m     = md_stall;
            flush_e     = (lw_stall | br_stall | (pcsrc && !BR_IN_D)) && !md_stall;
            flush_d     = pcsrc && !any_stall;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (stall_f && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stall_count = count_q;

endmodule
